// File: rtl/dino_pkg.sv
// Shared definitions for the dino game blocks.
// Contents: obstacle FSM state encoding, default respawn x and the
// LFSR seed/tap mask shared by every pseudo-random source.
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } obs_state_t;

    localparam int          SPAWN_X_DEF = 600;

    // x^8 + x^6 + x^5 + x^4 + 1, feedback from bits 7,5,4,3 of a left shifter
    localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
    localparam logic [7:0]  LFSR_SEED   = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, free-running every clock outside reset.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, active-low (loads LFSR_SEED)
//   o_value  out  current LFSR value, never zero
module lfsr8
    import dino_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] o_value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_value <= LFSR_SEED;
        end else begin
            o_value <= {o_value[6:0], ^(o_value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/obs_controller.sv
// Obstacle position controller: scrolls the obstacle left once per frame,
// respawns it after a pseudo-random gap and raises speed as obstacles pass.
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous reset, active-low
//   i_frame_tick  in   one-cycle pulse per frame
//   i_start       in   one-cycle pulse, start/restart game
//   i_collision   in   level, dino/obstacle overlap
//   o_xpos        out  obstacle x (XW bits) to the renderer
//   o_active      out  obstacle on screen (RUN)
//   o_passed      out  one-cycle pulse when the obstacle exits left
//   o_speed       out  current speed, hpos units per frame
//   o_halted      out  game over (HALT)
//
// state | meaning
// IDLE  | waiting for the first start
// RUN   | obstacle on screen, moving left each frame
// WAIT  | obstacle off screen, counting down the respawn gap
// HALT  | collision seen, everything frozen until start
module obs_controller
    import dino_pkg::*;
#(
    parameter int CONV       = 0,
    parameter int SPAWN_X    = SPAWN_X_DEF,
    parameter int MIN_GAP    = 16,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 12,
    parameter int SPEED_STEP = 8,
    localparam int XW        = 10 - CONV
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_frame_tick,
    input  logic          i_start,
    input  logic          i_collision,
    output logic [XW-1:0] o_xpos,
    output logic          o_active,
    output logic          o_passed,
    output logic [3:0]    o_speed,
    output logic          o_halted
);

    localparam int            PCW      = $clog2(SPEED_STEP) + 1;
    localparam logic [XW-1:0] SPAWN_XS = XW'(SPAWN_X >> CONV);

    obs_state_t     state_q, state_d;
    logic [XW-1:0]  xpos_q, xpos_d;
    logic [3:0]     speed_q, speed_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [5:0]     gap_q, gap_d;
    logic           passed_d;
    logic [7:0]     lfsr_value;
    logic           unused_lfsr_hi;

    lfsr8 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_value (lfsr_value)
    );

    // only the low nibble feeds the gap; upper bits serve other consumers
    assign unused_lfsr_hi = ^lfsr_value[7:4];

    always_comb begin
        state_d  = state_q;
        xpos_d   = xpos_q;
        speed_d  = speed_q;
        pcnt_d   = pcnt_q;
        gap_d    = gap_q;
        passed_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // start also overrides a collision still held high in HALT
                if (i_start) begin
                    state_d = ST_RUN;
                    xpos_d  = SPAWN_XS;
                    speed_d = 4'(SPEED_INIT);
                    pcnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (i_collision) begin
                    state_d = ST_HALT;
                end else if (i_frame_tick) begin
                    if (xpos_q >= XW'(speed_q)) begin
                        xpos_d = xpos_q - XW'(speed_q);
                    end else begin
                        state_d  = ST_WAIT;
                        xpos_d   = SPAWN_XS;
                        passed_d = 1'b1;
                        gap_d    = 6'(MIN_GAP) + {2'b00, lfsr_value[3:0]};
                        if (pcnt_q == PCW'(SPEED_STEP - 1)) begin
                            pcnt_d = '0;
                            if (speed_q < 4'(SPEED_MAX)) begin
                                speed_d = speed_q + 4'd1;
                            end
                        end else begin
                            pcnt_d = pcnt_q + PCW'(1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (i_collision) begin
                    state_d = ST_HALT;
                end else if (i_frame_tick) begin
                    gap_d = gap_q - 6'd1;
                    if (gap_q == 6'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            xpos_q   <= SPAWN_XS;
            speed_q  <= 4'(SPEED_INIT);
            pcnt_q   <= '0;
            gap_q    <= '0;
            o_passed <= 1'b0;
            o_active <= 1'b0;
            o_halted <= 1'b0;
        end else begin
            state_q  <= state_d;
            xpos_q   <= xpos_d;
            speed_q  <= speed_d;
            pcnt_q   <= pcnt_d;
            gap_q    <= gap_d;
            o_passed <= passed_d;
            o_active <= (state_d == ST_RUN);
            o_halted <= (state_d == ST_HALT);
        end
    end

    assign o_xpos  = xpos_q;
    assign o_speed = speed_q;

endmodule

// File: tb/tb_obs_controller.sv
// Self-checking bench for obs_controller: directed game scenarios plus a
// randomized phase, all compared every cycle against a frame-level model.
module tb_obs_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] xpos;
    logic       active;
    logic       passed;
    logic [3:0] speed;
    logic       halted;

    int n_chk = 0;
    int n_fail = 0;

    // model: game phase as a small integer, independent of the RTL encoding
    localparam int P_IDLE = 10, P_MOVE = 11, P_GAP = 12, P_OVER = 13;
    int         m_phase;
    int         m_x, m_spd, m_cnt, m_gap;
    bit         m_passed;
    logic [7:0] m_rand;

    obs_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (frame_tick),
        .i_start      (start),
        .i_collision  (collision),
        .o_xpos       (xpos),
        .o_active     (active),
        .o_passed     (passed),
        .o_speed      (speed),
        .o_halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic new_game();
        m_phase = P_MOVE;
        m_x     = 600;
        m_spd   = 2;
        m_cnt   = 0;
    endtask

    // one clock of game rules, applied with the inputs present at the edge
    task automatic model_edge();
        if (!rst_n) begin
            m_phase  = P_IDLE;
            m_x      = 600;
            m_spd    = 2;
            m_cnt    = 0;
            m_gap    = 0;
            m_passed = 0;
            m_rand   = 8'hA5;
            return;
        end
        m_passed = 0;
        if (m_phase == P_IDLE || m_phase == P_OVER) begin
            if (start) new_game();
        end else if (collision) begin
            m_phase = P_OVER;
        end else if (frame_tick) begin
            if (m_phase == P_MOVE) begin
                if (m_x >= m_spd) begin
                    m_x = m_x - m_spd;
                end else begin
                    m_x      = 600;
                    m_passed = 1;
                    m_gap    = 16 + int'(m_rand % 16);
                    m_phase  = P_GAP;
                    m_cnt    = (m_cnt + 1) % 8;
                    if (m_cnt == 0 && m_spd < 12) m_spd = m_spd + 1;
                end
            end else begin
                m_gap = m_gap - 1;
                if (m_gap == 0) m_phase = P_MOVE;
            end
        end
        m_rand = {m_rand[6:0], m_rand[7] ^ m_rand[5] ^ m_rand[4] ^ m_rand[3]};
    endtask

    task automatic compare_all();
        chk("xpos",   xpos,   m_x);
        chk("speed",  speed,  m_spd);
        chk("active", active, (m_phase == P_MOVE));
        chk("halted", halted, (m_phase == P_OVER));
        chk("passed", passed, m_passed);
    endtask

    task automatic step(input logic t, input logic s, input logic c);
        frame_tick = t;
        start      = s;
        collision  = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int exits;
        int cnt;
        int exp_gap;
        bit seen;

        // 1: reset, ticks without start leave the block idle
        rst_n = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        repeat (3) step(1, 0, 0);
        chk("t1_xpos", xpos, 600);
        chk("t1_active", active, 0);
        chk("t1_speed", speed, 2);

        // 2: start and ten frames at speed 2
        step(0, 1, 0);
        repeat (10) step(1, 0, 0);
        chk("t2_xpos", xpos, 580);
        chk("t2_active", active, 1);

        // 5: collision beats a same-cycle tick at x=100, start beats collision
        repeat (240) step(1, 0, 0);
        chk("t5_pre_xpos", xpos, 100);
        step(1, 0, 1);
        chk("t5_halted", halted, 1);
        chk("t5_xpos", xpos, 100);
        chk("t5_passed", passed, 0);
        step(0, 1, 1);
        chk("t5_restart_active", active, 1);
        chk("t5_restart_xpos", xpos, 600);
        chk("t5_restart_halted", halted, 0);
        step(0, 0, 0);

        // 3: run to exit, one-cycle pulse, respawn after 16..31 ticks
        seen = 0;
        cnt  = 0;
        while (!seen && cnt < 400) begin
            step(1, 0, 0);
            cnt++;
            if (passed) seen = 1;
        end
        chk("t3_exit_seen", seen, 1);
        exp_gap = m_gap;
        chk("t3_exit_xpos", xpos, 600);
        chk("t3_exit_active", active, 0);
        step(0, 0, 0);
        chk("t3_pulse_width", passed, 0);
        cnt = 0;
        while (!active && cnt < 40) begin
            step(1, 0, 0);
            cnt++;
        end
        chk("t3_gap_ticks", cnt, exp_gap);
        chk("t3_gap_range", (cnt >= 16 && cnt <= 31), 1);
        exits = 1;

        // 4: eighth exit raises speed to 3, then saturation at 12
        cnt = 0;
        while (exits < 8 && cnt < 20000) begin
            step(($urandom_range(0, 3) != 0), 0, 0);
            cnt++;
            if (passed) exits++;
        end
        chk("t4_exits8", exits, 8);
        chk("t4_speed3", speed, 3);
        cnt = 0;
        while (speed != 4'd12 && cnt < 40000) begin
            step(($urandom_range(0, 3) != 0), 0, 0);
            cnt++;
        end
        chk("t4_speed12", speed, 12);
        exits = 0;
        cnt   = 0;
        while (exits < 8 && cnt < 4000) begin
            step(1, 0, 0);
            cnt++;
            if (passed) exits++;
        end
        chk("t4_more_exits", exits, 8);
        chk("t4_speed_sat", speed, 12);

        // random play: ticks, stray starts and occasional collisions
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        // 6: reset in the middle of WAIT
        step(0, 1, 0);
        seen = 0;
        cnt  = 0;
        while (!seen && cnt < 800) begin
            step(1, 0, 0);
            cnt++;
            if (passed) seen = 1;
        end
        chk("t6_exit_seen", seen, 1);
        repeat (3) step(1, 0, 0);
        chk("t6_in_wait", active, 0);
        rst_n = 1'b0;
        step(1, 1, 0);
        chk("t6_xpos", xpos, 600);
        chk("t6_speed", speed, 2);
        chk("t6_active", active, 0);
        chk("t6_passed", passed, 0);
        chk("t6_halted", halted, 0);
        chk("t6_lfsr", dut.u_lfsr.o_value, 8'hA5);
        rst_n = 1'b1;
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
